maxnet_controller: RTL and testbench

Iteration sequencer for the Maxnet winner-take-all network. Accepts four IEEE-754 single-precision neuron activations and drives four weighted-sum processing units (one per neuron, each computing four products and an adder tree) with the current activations and the fixed Maxnet weight matrix. It captures their results, applies ReLU, and repeats until at most one neuron remains positive. It then reports the winning index and value.

---
 rtl/maxnet_pkg.sv | 9 +
 rtl/maxnet_weight_rom.sv | 15 +
 rtl/maxnet_controller.sv | 101 ++++++++++
 tb/tb_maxnet_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// maxnet_pkg: shared state encoding, float constants and ReLU for the Maxnet sequencer
package maxnet_pkg;
    typedef enum logic [1:0] {IDLE, CALC, UPDATE, DONE} state_t;
    localparam logic [31:0] FP_ONE = 32'h3F800000;
    localparam logic [31:0] FP_ZERO = 32'h00000000;
    function automatic logic [31:0] relu(input logic [31:0] x);
        return x[31] ? FP_ZERO : x;
    endfunction
endpackage

// File: rtl/maxnet_weight_rom.sv
// maxnet_weight_rom: constant Maxnet weight matrix, 1.0 on the diagonal and NEG_EPS elsewhere
module maxnet_weight_rom
    import maxnet_pkg::*;
#(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] NEG_EPS = 32'hBE4CCCCD
) (
    output logic [16*XLEN-1:0] pu_weight
);
    for (genvar j = 0; j < 4; j++) begin : g_pu
        for (genvar i = 0; i < 4; i++) begin : g_in
            assign pu_weight[(4*j+i)*XLEN +: XLEN] = (i == j) ? FP_ONE : NEG_EPS;
        end
    end
endmodule

// File: rtl/maxnet_controller.sv
// maxnet_controller: iterates four external weighted-sum PUs with ReLU until at most one neuron stays positive
module maxnet_controller
    import maxnet_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PU_LATENCY = 3,
    parameter logic [XLEN-1:0] NEG_EPS = 32'hBE4CCCCD,
    parameter int MAX_ITER = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*XLEN-1:0]    act_in,
    output logic [4*XLEN-1:0]    pu_num,
    output logic [16*XLEN-1:0]   pu_weight,
    input  logic [4*XLEN-1:0]    pu_result,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           winner,
    output logic [XLEN-1:0]      winner_value,
    output logic                 no_winner,
    output logic                 timeout,
    output logic [7:0]           iter_count
);
    localparam int CW = $clog2(PU_LATENCY + 1);

    state_t state, state_nxt;
    logic [3:0][XLEN-1:0] act_reg, res_reg, relu_res;
    logic [3:0] nz;
    logic [2:0] nz_count;
    logic [1:0] win_idx;
    logic [CW-1:0] cnt;
    logic last_iter;

    maxnet_weight_rom #(.XLEN(XLEN), .NEG_EPS(NEG_EPS)) u_rom (.pu_weight(pu_weight));

    assign pu_num = act_reg;

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            relu_res[j] = relu(res_reg[j]);
            nz[j] = |relu_res[j][XLEN-2:0];
        end
        nz_count = {2'b0, nz[0]} + {2'b0, nz[1]} + {2'b0, nz[2]} + {2'b0, nz[3]};
        win_idx = nz[0] ? 2'd0 : nz[1] ? 2'd1 : nz[2] ? 2'd2 : nz[3] ? 2'd3 : 2'd0;
        last_iter = (int'(iter_count) + 1 == MAX_ITER);
    end

    always_comb begin
        state_nxt = (state == IDLE)   ? (start ? CALC : IDLE) :
                    (state == CALC)   ? ((cnt == '0) ? UPDATE : CALC) :
                    (state == UPDATE) ? ((nz_count <= 3'd1 || last_iter) ? DONE : CALC) :
                                        IDLE;
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            act_reg <= '0;
            res_reg <= '0;
            cnt <= '0;
            iter_count <= '0;
            winner <= '0;
            winner_value <= '0;
            no_winner <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                for (int j = 0; j < 4; j++) act_reg[j] <= relu(act_in[j*XLEN +: XLEN]);
                cnt <= CW'(PU_LATENCY);
                iter_count <= '0;
                winner <= '0;
                winner_value <= '0;
                no_winner <= 1'b0;
                timeout <= 1'b0;
            end
            if (state == CALC) begin
                cnt <= cnt - 1'b1;
                if (cnt == '0) res_reg <= pu_result;
            end
            // results are latched on the way into DONE so they hold through IDLE
            if (state == UPDATE) begin
                act_reg <= relu_res;
                iter_count <= (iter_count == 8'hFF) ? iter_count : iter_count + 8'd1;
                cnt <= CW'(PU_LATENCY);
                if (state_nxt == DONE) begin
                    winner <= win_idx;
                    winner_value <= relu_res[win_idx];
                    no_winner <= (nz_count == 3'd0);
                    timeout <= (nz_count > 3'd1);
                end
            end
        end
    end
endmodule

// File: tb/tb_maxnet_controller.sv
// tb_maxnet_controller: randomized and directed runs checked against an iterative Maxnet reference model
module tb_maxnet_controller;
    localparam int MI = 8;
    localparam logic [31:0] EPS = 32'hBE4CCCCD;

    logic clk = 0, rst, start;
    logic [127:0] act_in, pu_num, pu_result;
    logic [511:0] pu_weight;
    logic busy, done, no_winner, timeout;
    logic [1:0] winner;
    logic [31:0] winner_value;
    logic [7:0] iter_count;
    int checks = 0, errors = 0;

    maxnet_controller #(.MAX_ITER(MI)) dut (
        .clk(clk), .rst(rst), .start(start), .act_in(act_in), .pu_num(pu_num),
        .pu_weight(pu_weight), .pu_result(pu_result), .busy(busy), .done(done),
        .winner(winner), .winner_value(winner_value), .no_winner(no_winner),
        .timeout(timeout), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == 8'd0) return 0.0;
        d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [30:0] em;
        int e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        if (e <= 0) return {d[63], 31'b0};
        em = {8'(e), d[51:29]};
        if (d[28] && ((|d[27:0]) || d[29])) em = em + 31'd1;
        return {d[63], em};
    endfunction

    function automatic logic [31:0] relu_f(input logic [31:0] x);
        return x[31] ? 32'h0 : x;
    endfunction

    // four PUs: weighted sum of pu_num, three-cycle pipeline
    logic [31:0] p0[4], p1[4], p2[4];
    function automatic logic [31:0] pu_calc(input int j);
        real s = 0.0;
        for (int i = 0; i < 4; i++) s += f2r(pu_num[i*32 +: 32]) * f2r(pu_weight[(4*j+i)*32 +: 32]);
        return r2f(s);
    endfunction
    always @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            p0[j] <= pu_calc(j);
            p1[j] <= p0[j];
            p2[j] <= p1[j];
        end
    end
    assign pu_result = {p2[3], p2[2], p2[1], p2[0]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        logic [31:0] diff;
        diff = (obs > exp) ? obs - exp : exp - obs;
        checks++;
        assert (!$isunknown(obs) && diff <= 32'd1) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [31:0] ain[4], output int n, output logic [1:0] w,
                         output logic [31:0] v, output logic nw, output logic to);
        logic [31:0] a[4], b[4];
        int c;
        real s;
        for (int i = 0; i < 4; i++) a[i] = relu_f(ain[i]);
        n = 0;
        do begin
            for (int j = 0; j < 4; j++) begin
                s = 0.0;
                for (int i = 0; i < 4; i++) s += f2r(a[i]) * ((i == j) ? 1.0 : f2r(EPS));
                b[j] = relu_f(r2f(s));
            end
            a = b;
            n++;
            c = 0;
            for (int j = 0; j < 4; j++) if (a[j][30:0] != 0) c++;
        end while (c > 1 && n < MI);
        w = 0;
        v = 0;
        for (int j = 3; j >= 0; j--) if (a[j][30:0] != 0) begin w = 2'(j); v = a[j]; end
        nw = (c == 0);
        to = (c > 1);
    endtask

    task automatic run(input logic [31:0] a0, a1, a2, a3, input bit hold);
        logic [31:0] ain[4];
        int n, edges;
        logic [1:0] w;
        logic [31:0] v;
        logic nw, to;
        ain = '{a0, a1, a2, a3};
        model(ain, n, w, v, nw, to);
        @(negedge clk);
        chk("idle_before_start", {31'b0, busy}, 32'd0);
        act_in = {a3, a2, a1, a0};
        start = 1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 0;
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        edges = 0;
        while (!done && edges < 5 * MI + 10) begin
            if (edges < 4) begin
                chk("pu_num_lo", pu_num[63:0], {relu_f(a1), relu_f(a0)});
                chk("pu_num_hi", pu_num[127:96], relu_f(a3));
            end
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        chk("done_latency", edges, 5 * n);
        chk("iter_count", {24'b0, iter_count}, n);
        chk("winner", {30'b0, winner}, {30'b0, w});
        chk_near("winner_value", winner_value, v);
        chk("no_winner", {31'b0, no_winner}, {31'b0, nw});
        chk("timeout", {31'b0, timeout}, {31'b0, to});
    endtask

    function automatic logic [31:0] rnd_val();
        real r;
        if ($urandom_range(0, 3) == 0) return 32'h0;
        r = real'($urandom_range(1, 1024)) / 256.0;
        return r2f($urandom_range(0, 2) == 0 ? -r : r);
    endfunction

    initial begin
        bit seen_done;
        rst = 1;
        start = 0;
        act_in = '0;
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_pu_num", pu_num[31:0] | pu_num[63:32] | pu_num[95:64] | pu_num[127:96], 32'd0);
        chk("rst_iter", {24'b0, iter_count}, 32'd0);
        chk("rst_winner_value", winner_value, 32'd0);
        chk("rst_flags", {29'b0, winner, no_winner | timeout}, 32'd0);
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++)
                chk($sformatf("weight_%0d_%0d", j, i), pu_weight[(4*j+i)*32 +: 32],
                    (i == j) ? 32'h3F800000 : EPS);

        run(32'h3F800000, 32'h0, 32'h0, 32'h0, 0);
        chk("single_iter", {24'b0, iter_count}, 32'd1);
        chk("single_value", winner_value, 32'h3F800000);

        run(32'h3F800000, 32'h3F000000, 32'h0, 32'h0, 0);
        chk("two_iter", {24'b0, iter_count}, 32'd3);
        chk("two_winner", {30'b0, winner}, 32'd0);
        chk_near("two_value", winner_value, r2f(0.816));

        run(32'hBF800000, 32'hC0000000, 32'h80000000, 32'hC0400000, 0);
        chk("neg_no_winner", {31'b0, no_winner}, 32'd1);
        chk("neg_value", winner_value, 32'd0);

        run(32'h3F000000, 32'h3F000000, 32'h0, 32'h0, 0);
        chk("sym_timeout", {31'b0, timeout}, 32'd1);
        chk("sym_iter", {24'b0, iter_count}, MI);

        @(negedge clk);
        act_in = {32'h0, 32'h0, 32'h3F000000, 32'h3F000000};
        start = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        repeat (6) @(negedge clk);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_iter", {24'b0, iter_count}, 32'd0);
        chk("abort_pu_num", pu_num[63:0] == 64'd0 ? 32'd0 : 32'd1, 32'd0);
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            seen_done |= done;
        end
        chk("abort_no_done", {31'b0, seen_done}, 32'd0);
        run(32'h0, 32'h3F800000, 32'h3F000000, 32'h0, 0);

        run(32'h3F800000, 32'h3F400000, 32'h0, 32'h0, 1);
        run(32'h0, 32'h0, 32'h3E800000, 32'h3F800000, 0);

        repeat (8) run(rnd_val(), rnd_val(), rnd_val(), rnd_val(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
